// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues sequential word-aligned fetch addresses under
// a credit limit, buffers returned instructions with their PCs in a small FIFO
// for decode, and on a taken branch flushes the FIFO and drops stale responses.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    PC_WIDTH   = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ifu_req_addr_vld,
    output logic [ADDR_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_rsp_data_vld,
    input  logic [INST_WIDTH-1:0] ifu_rsp_data,
    output logic                  ifu_vld,
    output logic [PC_WIDTH-1:0]   ifu_pc,
    output logic [INST_WIDTH-1:0] ifu_inst,
    input  logic                  dec_rdy,
    input  logic                  alu_branch_taken,
    input  logic [PC_WIDTH-1:0]   alu_branch_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]       DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    localparam logic [PW-1:0]     PTR_ONE = PW'(1);
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   rsp_pc;
    logic [PC_WIDTH-1:0]   fifo_pc   [DEPTH];
    logic [INST_WIDTH-1:0] fifo_inst [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_cnt;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         discard;

    logic [CW:0]           credit_used;
    logic [PC_WIDTH-1:0]   branch_target;
    logic                  issue;
    logic                  rsp_take;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         inflight_nxt;
    logic [CW-1:0]         fifo_cnt_nxt;

    // Every request ever issued holds a FIFO slot until its instruction is
    // popped or discarded, so the FIFO can never overflow.
    assign credit_used   = {1'b0, fifo_cnt} + {1'b0, inflight};
    assign branch_target = alu_branch_pc & ~PC_WIDTH'(3);
    assign issue         = rst_n && !alu_branch_taken && (credit_used < DEPTH_C);
    // A response with nothing outstanding belongs to no request of ours.
    assign rsp_take      = ifu_rsp_data_vld && (inflight != '0);
    assign push          = rsp_take && (discard == '0) && !alu_branch_taken;
    assign ifu_vld       = (fifo_cnt != '0) && !alu_branch_taken;
    assign pop           = ifu_vld && dec_rdy;

    assign ifu_req_addr_vld = issue;
    assign ifu_req_addr     = fetch_pc;
    assign ifu_pc           = fifo_pc[rd_ptr];
    assign ifu_inst         = fifo_inst[rd_ptr];

    // Next-state occupancy counters; issue and response may cancel out.
    always_comb begin
        inflight_nxt = inflight;
        if (issue && !rsp_take) begin
            inflight_nxt = inflight + CNT_ONE;
        end else if (!issue && rsp_take) begin
            inflight_nxt = inflight - CNT_ONE;
        end
        fifo_cnt_nxt = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_nxt = fifo_cnt + CNT_ONE;
        end else if (!push && pop) begin
            fifo_cnt_nxt = fifo_cnt - CNT_ONE;
        end
    end

    // Instruction buffer storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_inst[wr_ptr] <= ifu_rsp_data;
        end
    end

    // PCs, FIFO pointers and credit/discard bookkeeping, including redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (alu_branch_taken) begin
                // Everything still outstanding after this edge is wrong-path,
                // which already includes any responses pending a discard.
                fetch_pc <= branch_target;
                rsp_pc   <= branch_target;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                discard  <= inflight_nxt;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_take && (discard != '0)) begin
                    discard <= discard - CNT_ONE;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                fifo_cnt <= fifo_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with an in-order fixed-latency memory model.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n0 = 1'b0;
    logic        rst_n1 = 1'b0;
    logic        ifu_rsp_data_vld = 1'b0;
    logic [31:0] ifu_rsp_data = '0;
    logic        dec_rdy = 1'b0;
    logic        alu_branch_taken = 1'b0;
    logic [31:0] alu_branch_pc = '0;

    logic        r0_req_vld, r1_req_vld, r0_vld, r1_vld;
    logic [31:0] r0_req_addr, r1_req_addr, r0_pc, r1_pc, r0_inst, r1_inst;

    bit          sel = 1'b0;
    logic        req_vld_m, vld_m;
    logic [31:0] req_addr_m, pc_m, inst_m;

    assign req_vld_m  = sel ? r1_req_vld  : r0_req_vld;
    assign req_addr_m = sel ? r1_req_addr : r0_req_addr;
    assign vld_m      = sel ? r1_vld      : r0_vld;
    assign pc_m       = sel ? r1_pc       : r0_pc;
    assign inst_m     = sel ? r1_inst     : r0_inst;

    ifu_fetch #(.RESET_PC(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n0),
        .ifu_req_addr_vld(r0_req_vld), .ifu_req_addr(r0_req_addr),
        .ifu_rsp_data_vld(ifu_rsp_data_vld), .ifu_rsp_data(ifu_rsp_data),
        .ifu_vld(r0_vld), .ifu_pc(r0_pc), .ifu_inst(r0_inst),
        .dec_rdy(dec_rdy), .alu_branch_taken(alu_branch_taken),
        .alu_branch_pc(alu_branch_pc)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst_n(rst_n1),
        .ifu_req_addr_vld(r1_req_vld), .ifu_req_addr(r1_req_addr),
        .ifu_rsp_data_vld(ifu_rsp_data_vld), .ifu_rsp_data(ifu_rsp_data),
        .ifu_vld(r1_vld), .ifu_pc(r1_pc), .ifu_inst(r1_inst),
        .dec_rdy(dec_rdy), .alu_branch_taken(alu_branch_taken),
        .alu_branch_pc(alu_branch_pc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          first_vld = -1;
    logic        last_req_vld = 1'b0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] req_log   [$];
    logic [31:0] got_pc    [$];
    logic [31:0] got_inst  [$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + 32'h0101_0101;
    endfunction

    task automatic clear_model();
        pend_addr.delete(); pend_due.delete(); req_log.delete();
        got_pc.delete(); got_inst.delete();
        cyc = 0; first_vld = -1;
    endtask

    // Leaves both DUTs in reset, sitting just after a falling edge.
    task automatic do_reset(input bit s);
        sel = s;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        dec_rdy = 1'b0; alu_branch_taken = 1'b0; alu_branch_pc = '0;
        ifu_rsp_data_vld = 1'b0; ifu_rsp_data = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        clear_model();
        @(negedge clk);
        if (sel) rst_n1 = 1'b1; else rst_n0 = 1'b1;
    endtask

    // One cycle: drive inputs and memory response, sample, advance to next falling edge.
    task automatic step(input logic rdy, input logic br, input logic [31:0] bpc);
        dec_rdy = rdy; alu_branch_taken = br; alu_branch_pc = bpc;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            ifu_rsp_data_vld = 1'b1;
            ifu_rsp_data = mem_f(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end else begin
            ifu_rsp_data_vld = 1'b0;
            ifu_rsp_data = '0;
        end
        #1;
        last_req_vld = req_vld_m;
        if (req_vld_m) begin
            req_log.push_back(req_addr_m);
            pend_addr.push_back(req_addr_m);
            pend_due.push_back(cyc + lat);
        end
        if (vld_m && rdy) begin
            got_pc.push_back(pc_m);
            got_inst.push_back(inst_m);
        end
        if (vld_m && first_vld < 0) first_vld = cyc;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        logic [31:0] exp_req [3];
        exp_req[0] = 32'h0; exp_req[1] = 32'h4; exp_req[2] = 32'h8;
        do_reset(1'b0);
        n_cmp++; if (req_vld_m !== 1'b0) begin n_bad++; $display("FAIL rst_req_vld got %b want 0", req_vld_m); end
        n_cmp++; if (req_addr_m !== 32'h0) begin n_bad++; $display("FAIL rst_req_addr got %h want 00000000", req_addr_m); end
        n_cmp++; if (vld_m !== 1'b0) begin n_bad++; $display("FAIL rst_ifu_vld got %b want 0", vld_m); end
        n_cmp++; if (pc_m !== 32'h0) begin n_bad++; $display("FAIL rst_ifu_pc got %h want 00000000", pc_m); end
        n_cmp++; if (inst_m !== 32'h0) begin n_bad++; $display("FAIL rst_ifu_inst got %h want 00000000", inst_m); end
        lat = 1;
        release_reset();
        step(1'b0, 1'b0, '0);
        n_cmp++; if (last_req_vld !== 1'b1) begin n_bad++; $display("FAIL first_issue got %b want 1", last_req_vld); end
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        n_cmp++; if (req_log.size() !== 3) begin n_bad++; $display("FAIL reset_req_count got %0d want 3", req_log.size()); end
        for (int i = 0; i < 3; i++) begin
            if (req_log.size() > i) begin
                n_cmp++; if (req_log[i] !== exp_req[i]) begin n_bad++; $display("FAIL reset_req[%0d] got %h want %h", i, req_log[i], exp_req[i]); end
            end
        end
    endtask

    task automatic test_straight();
        do_reset(1'b0);
        lat = 1;
        release_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
        n_cmp++; if (first_vld !== 2) begin n_bad++; $display("FAIL first_vld_cycle got %0d want 2", first_vld); end
        n_cmp++; if (got_pc.size() !== 10) begin n_bad++; $display("FAIL straight_count got %0d want 10", got_pc.size()); end
        for (int i = 0; i < 10; i++) begin
            if (got_pc.size() > i) begin
                n_cmp++; if (got_pc[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL straight_pc[%0d] got %h want %h", i, got_pc[i], 32'(4 * i)); end
                n_cmp++; if (got_inst[i] !== mem_f(32'(4 * i))) begin n_bad++; $display("FAIL straight_inst[%0d] got %h want %h", i, got_inst[i], mem_f(32'(4 * i))); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        lat = 1;
        release_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        n_cmp++; if (req_log.size() !== 4) begin n_bad++; $display("FAIL bp_req_count got %0d want 4", req_log.size()); end
        n_cmp++; if (last_req_vld !== 1'b0) begin n_bad++; $display("FAIL bp_stalled got %b want 0", last_req_vld); end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        if (req_log.size() > 4) begin
            n_cmp++; if (req_log[4] !== 32'h10) begin n_bad++; $display("FAIL bp_resume_addr got %h want 00000010", req_log[4]); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL bp_resume_addr got none want 00000010");
        end
        n_cmp++; if (got_pc.size() < 5) begin n_bad++; $display("FAIL bp_drain_count got %0d want >=5", got_pc.size()); end
        for (int i = 0; i < 5; i++) begin
            if (got_pc.size() > i) begin
                n_cmp++; if (got_pc[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_drain_pc[%0d] got %h want %h", i, got_pc[i], 32'(4 * i)); end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        lat = 3;
        release_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h103);
        n_cmp++; if (last_req_vld !== 1'b0) begin n_bad++; $display("FAIL redir_no_issue got %b want 0", last_req_vld); end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        if (req_log.size() > 2) begin
            n_cmp++; if (req_log[2] !== 32'h100) begin n_bad++; $display("FAIL redir_req got %h want 00000100", req_log[2]); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL redir_req got none want 00000100");
        end
        n_cmp++; if (got_pc.size() < 2) begin n_bad++; $display("FAIL redir_count got %0d want >=2", got_pc.size()); end
        if (got_pc.size() > 1) begin
            n_cmp++; if (got_pc[0] !== 32'h100) begin n_bad++; $display("FAIL redir_pc0 got %h want 00000100", got_pc[0]); end
            n_cmp++; if (got_inst[0] !== mem_f(32'h100)) begin n_bad++; $display("FAIL redir_inst0 got %h want %h", got_inst[0], mem_f(32'h100)); end
            n_cmp++; if (got_pc[1] !== 32'h104) begin n_bad++; $display("FAIL redir_pc1 got %h want 00000104", got_pc[1]); end
        end
    endtask

    task automatic test_redirect_rsp();
        do_reset(1'b0);
        lat = 3;
        release_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, '0);
        if (req_log.size() > 3) begin
            n_cmp++; if (req_log[3] !== 32'h200) begin n_bad++; $display("FAIL rsp_redir_req got %h want 00000200", req_log[3]); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL rsp_redir_req got none want 00000200");
        end
        n_cmp++; if (got_pc.size() < 3) begin n_bad++; $display("FAIL rsp_redir_count got %0d want >=3", got_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (got_pc.size() > i) begin
                n_cmp++; if (got_pc[i] !== 32'h200 + 32'(4 * i)) begin n_bad++; $display("FAIL rsp_redir_pc[%0d] got %h want %h", i, got_pc[i], 32'h200 + 32'(4 * i)); end
                n_cmp++; if (got_inst[i] !== mem_f(32'h200 + 32'(4 * i))) begin n_bad++; $display("FAIL rsp_redir_inst[%0d] got %h want %h", i, got_inst[i], mem_f(32'h200 + 32'(4 * i))); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        lat = 1;
        release_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h300);
        step(1'b1, 1'b1, 32'h400);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
        if (req_log.size() > 2) begin
            n_cmp++; if (req_log[2] !== 32'h400) begin n_bad++; $display("FAIL b2b_req got %h want 00000400", req_log[2]); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL b2b_req got none want 00000400");
        end
        if (got_pc.size() > 1) begin
            n_cmp++; if (got_pc[0] !== 32'h400) begin n_bad++; $display("FAIL b2b_pc0 got %h want 00000400", got_pc[0]); end
            n_cmp++; if (got_pc[1] !== 32'h404) begin n_bad++; $display("FAIL b2b_pc1 got %h want 00000404", got_pc[1]); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL b2b_count got %0d want >=2", got_pc.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        do_reset(1'b1);
        n_cmp++; if (req_addr_m !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_rst_addr got %h want fffffff8", req_addr_m); end
        lat = 1;
        release_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        n_cmp++; if (got_pc.size() !== 6) begin n_bad++; $display("FAIL wrap_count got %0d want 6", got_pc.size()); end
        for (int i = 0; i < 3; i++) begin
            if (got_pc.size() > i) begin
                n_cmp++; if (got_pc[i] !== exp_pc[i]) begin n_bad++; $display("FAIL wrap_pc[%0d] got %h want %h", i, got_pc[i], exp_pc[i]); end
            end
        end
        #1;
        n_cmp++; if (vld_m !== 1'b1) begin n_bad++; $display("FAIL wrap_streaming got %b want 1", vld_m); end
        rst_n1 = 1'b0;
        ifu_rsp_data_vld = 1'b0;
        #1;
        n_cmp++; if (vld_m !== 1'b0) begin n_bad++; $display("FAIL midrst_vld got %b want 0", vld_m); end
        n_cmp++; if (req_vld_m !== 1'b0) begin n_bad++; $display("FAIL midrst_req_vld got %b want 0", req_vld_m); end
        release_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
        if (req_log.size() > 0 && got_pc.size() > 0) begin
            n_cmp++; if (req_log[0] !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL midrst_req got %h want fffffff8", req_log[0]); end
            n_cmp++; if (got_pc[0] !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL midrst_pc got %h want fffffff8", got_pc[0]); end
        end else begin
            n_cmp++; n_bad++; $display("FAIL midrst_restart got %0d reqs %0d pops want >0", req_log.size(), got_pc.size());
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect();
        test_redirect_rsp();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
